// File: rtl/mont_pkg.sv
// Shared types for the Montgomery exponentiation datapath: operand layout and controller states.
// Used by the exponent controller, the multiplier and the Paillier top level.
package mont_pkg;

    localparam int unsigned MontWidth = 32;
    localparam int unsigned MontLimbs = 8;

    typedef logic [MontWidth-1:0] limb_t;
    typedef limb_t [MontLimbs-1:0] operand_t;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StSqr,
        StSqrWait,
        StMul,
        StMulWait,
        StFinish,
        StDrain
    } mexp_state_e;

    // States in which a multiply is outstanding and its operands must hold
    function automatic logic mexp_waiting(input mexp_state_e st);
        return (st == StSqrWait) || (st == StMulWait) || (st == StDrain);
    endfunction

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
// Computes base^exp in the Montgomery domain and reports the number of multiplies issued.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned S     = 8,
    parameter int unsigned EBITS = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [WIDTH*S-1:0]                 base,
    input  logic [WIDTH*S-1:0]                 one_m,
    input  logic [EBITS-1:0]                   exp,
    output logic                               busy,
    output logic                               done,
    output logic [WIDTH*S-1:0]                 result,
    output logic [$clog2(2*EBITS+1)-1:0]       mm_count,
    output logic                               mm_start,
    output logic [WIDTH*S-1:0]                 mm_a,
    output logic [WIDTH*S-1:0]                 mm_b,
    input  logic                               mm_done,
    input  logic [WIDTH*S-1:0]                 mm_result
);

    localparam int unsigned OpW  = WIDTH * S;
    localparam int unsigned IdxW = $clog2(EBITS);
    localparam int unsigned CntW = $clog2(2 * EBITS + 1);

    localparam logic [IdxW-1:0] IdxTop = IdxW'(EBITS - 1);
    localparam logic [IdxW-1:0] IdxOne = IdxW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    mexp_state_e     state_q, state_d;
    logic [OpW-1:0]  acc_q, acc_d;
    logic [OpW-1:0]  base_q, base_d;
    logic [EBITS-1:0] exp_q, exp_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            started_q, started_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [OpW-1:0]  result_q, result_d;
    logic [CntW-1:0] mm_count_q, mm_count_d;
    logic            mm_start_q, mm_start_d;
    logic [OpW-1:0]  mm_a_q, mm_a_d;
    logic [OpW-1:0]  mm_b_q, mm_b_d;
    logic            advance;
    logic            cur_bit;

    assign cur_bit = exp_q[idx_q];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        base_d     = base_q;
        exp_d      = exp_q;
        idx_d      = idx_q;
        started_d  = started_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        mm_count_d = mm_count_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_start_d = 1'b0;
        done_d     = 1'b0;
        advance    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d     = one_m;
                    base_d    = base;
                    exp_d     = exp;
                    idx_d     = IdxTop;
                    started_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!started_q) begin
                    // The first set bit seeds the accumulator without a multiply
                    if (cur_bit) begin
                        acc_d     = base_q;
                        started_d = 1'b1;
                    end
                    advance = 1'b1;
                end else begin
                    state_d    = StSqr;
                    mm_start_d = 1'b1;
                    mm_a_d     = acc_q;
                    mm_b_d     = acc_q;
                end
            end
            StSqr: begin
                cnt_d   = cnt_q + CntOne;
                state_d = abort ? StIdle : StSqrWait;
            end
            StSqrWait: begin
                if (mm_done) begin
                    acc_d = mm_result;
                    // Abort coinciding with completion leaves nothing to drain
                    if (abort) begin
                        state_d = StIdle;
                    end else if (cur_bit) begin
                        state_d    = StMul;
                        mm_start_d = 1'b1;
                        mm_a_d     = mm_result;
                        mm_b_d     = base_q;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (abort) begin
                    state_d = StDrain;
                end
            end
            StMul: begin
                cnt_d   = cnt_q + CntOne;
                state_d = abort ? StIdle : StMulWait;
            end
            StMulWait: begin
                if (mm_done) begin
                    acc_d = mm_result;
                    if (abort) begin
                        state_d = StIdle;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (abort) begin
                    state_d = StDrain;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            StDrain: begin
                if (mm_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            if (idx_q == '0) begin
                state_d = StFinish;
            end else begin
                idx_d   = idx_q - IdxOne;
                state_d = StScan;
            end
        end

        // Outputs are registered, so results are captured on entry to FINISH
        if (state_d == StFinish) begin
            done_d     = 1'b1;
            result_d   = acc_d;
            mm_count_d = cnt_d;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            base_q     <= '0;
            exp_q      <= '0;
            idx_q      <= '0;
            started_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            mm_count_q <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            idx_q      <= idx_d;
            started_q  <= started_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            mm_count_q <= mm_count_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mm_count = mm_count_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;

    a_mm_start_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        mm_start_q |=> !mm_start_q);

    a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        done_q |=> !done_q);

    a_operands_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (mexp_waiting(state_q) && !mm_done) |=> ($stable(mm_a_q) && $stable(mm_b_q)));

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a 4-cycle behavioural Montgomery multiplier (p=65521).
module tb_mont_exp_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned S     = 1;
    localparam int unsigned EBITS = 8;
    localparam int unsigned CntW  = 5;
    localparam int          L     = 4;
    localparam longint      P     = 65521;
    localparam longint      RINV  = 61153;
    localparam longint      ONE_M = 15;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [15:0]      base_in;
    logic [15:0]      one_m;
    logic [7:0]       exp_in;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic [CntW-1:0]  mm_count;
    logic             mm_start;
    logic [15:0]      mm_a;
    logic [15:0]      mm_b;
    logic             mm_done;
    logic [15:0]      mm_result;

    logic             model_done;
    logic             spur_done;
    int               mdl_left;

    typedef struct {
        logic [15:0]     res;
        logic [CntW-1:0] cnt;
        int              cyc;
    } exp_t;

    exp_t        sb[$];
    int          starts_q[$];
    int          checks;
    int          errors;
    int          last_done_cyc;
    logic [15:0] last_res;
    logic [CntW-1:0] last_cnt;

    mont_exp_ctrl #(
        .WIDTH(WIDTH),
        .S    (S),
        .EBITS(EBITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .base     (base_in),
        .one_m    (one_m),
        .exp      (exp_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mm_count (mm_count),
        .mm_start (mm_start),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_done  (mm_done),
        .mm_result(mm_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b);
        longint t;
        t = (longint'(a) * longint'(b)) % P;
        t = (t * RINV) % P;
        return t[15:0];
    endfunction

    // Multiplier: reads operands on the done edge so unstable operands corrupt the product
    assign mm_done = model_done | spur_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_left   <= 0;
            model_done <= 1'b0;
            mm_result  <= '0;
        end else begin
            model_done <= 1'b0;
            if (mm_start) begin
                mdl_left <= L - 1;
            end else if (mdl_left > 0) begin
                mdl_left <= mdl_left - 1;
                if (mdl_left == 1) begin
                    model_done <= 1'b1;
                    mm_result  <= mont(mm_a, mm_b);
                end
            end
        end
    end

    function automatic logic [15:0] to_mont(input longint x);
        longint t;
        t = (x * ONE_M) % P;
        return t[15:0];
    endfunction

    function automatic logic [15:0] exp_result(input logic [15:0] b, input logic [7:0] e);
        longint r;
        r = 1;
        for (int i = 0; i < int'(e); i++) r = (r * longint'(b)) % P;
        return to_mont(r);
    endfunction

    function automatic int msb_of(input logic [7:0] e);
        int m;
        m = -1;
        for (int i = 0; i < 8; i++) if (e[i]) m = i;
        return m;
    endfunction

    function automatic int exp_count(input logic [7:0] e);
        int pop;
        if (e == 8'd0) return 0;
        pop = 0;
        for (int i = 0; i < 8; i++) if (e[i]) pop++;
        return msb_of(e) + pop - 1;
    endfunction

    function automatic int exp_cycles(input logic [7:0] e);
        int c;
        int m;
        if (e == 8'd0) return EBITS + 1;
        m = msb_of(e);
        c = (EBITS - 1 - m) + 1;
        for (int i = m - 1; i >= 0; i--) c += e[i] ? (3 + 2 * L) : (2 + L);
        return c + 1;
    endfunction

    task automatic run_job(input logic [15:0] b, input logic [7:0] e, input int spur_cyc,
                           input int restart_cyc, input string name);
        exp_t x;
        exp_t got;
        int   cyc;
        bit   seen;
        x.res = exp_result(b, e);
        x.cnt = CntW'(exp_count(e));
        x.cyc = exp_cycles(e);
        sb.push_back(x);
        starts_q.delete();
        @(negedge clk);
        start   = 1'b1;
        base_in = to_mont(longint'(b));
        one_m   = 16'(ONE_M);
        exp_in  = e;
        cyc     = 0;
        seen    = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            spur_done = 1'b0;
            if (cyc == 1) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s cycle1 busy=%b done=%b want busy=1 done=0", name, busy, done);
                end
            end
            if (mm_start) starts_q.push_back(cyc);
            if (cyc == spur_cyc) spur_done = 1'b1;
            if (cyc == restart_cyc) begin
                start   = 1'b1;
                base_in = 16'h1111;
                exp_in  = 8'h0F;
            end
            if (done) seen = 1'b1;
        end
        start     = 1'b0;
        spur_done = 1'b0;
        got = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout no done after %0d cycles", name, cyc);
        end else begin
            last_done_cyc = cyc;
            last_res      = got.res;
            last_cnt      = got.cnt;
            if (result !== got.res) begin
                errors++;
                $display("FAIL %s result got %h want %h", name, result, got.res);
            end
            checks++;
            if (mm_count !== got.cnt) begin
                errors++;
                $display("FAIL %s mm_count got %0d want %0d", name, mm_count, got.cnt);
            end
            checks++;
            if (cyc != got.cyc) begin
                errors++;
                $display("FAIL %s done_cycle got %0d want %0d", name, cyc, got.cyc);
            end
            checks++;
            if (starts_q.size() != int'(got.cnt)) begin
                errors++;
                $display("FAIL %s mm_start_pulses got %0d want %0d", name, starts_q.size(),
                         got.cnt);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({busy, done, mm_start} !== 3'b000 || result !== '0 || mm_count !== '0 ||
            mm_a !== '0 || mm_b !== '0) begin
            errors++;
            $display("FAIL %s busy=%b done=%b mm_start=%b result=%h mm_count=%0d mm_a=%h mm_b=%h want all 0",
                     name, busy, done, mm_start, result, mm_count, mm_a, mm_b);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_in   = '0;
        one_m     = '0;
        exp_in    = '0;
        spur_done = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_outputs_zero("reset_asserted");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_released");
    endtask

    task automatic test_exp5;
        int want[3];
        want = '{8, 14, 19};
        run_job(16'd1234, 8'b0000_0101, -1, -1, "exp5");
        checks++;
        if (last_done_cyc != 24) begin
            errors++;
            $display("FAIL exp5_done_cycle got %0d want 24", last_done_cyc);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (starts_q.size() <= i || starts_q[i] != want[i]) begin
                errors++;
                $display("FAIL exp5_mm_start_%0d got %0d want %0d", i,
                         (starts_q.size() > i) ? starts_q[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_exp_zero;
        run_job(16'd500, 8'h00, -1, -1, "exp_zero");
        checks++;
        if (last_done_cyc != 9 || result !== 16'd15 || starts_q.size() != 0) begin
            errors++;
            $display("FAIL exp_zero cycle=%0d result=%h starts=%0d want 9 000f 0",
                     last_done_cyc, result, starts_q.size());
        end
    endtask

    task automatic test_all_ones;
        run_job(16'd1, 8'hFF, -1, -1, "all_ones");
        checks++;
        if (last_done_cyc != 79 || result !== 16'd15 || mm_count !== 5'd14) begin
            errors++;
            $display("FAIL all_ones cycle=%0d result=%h mm_count=%0d want 79 000f 14",
                     last_done_cyc, result, mm_count);
        end
    endtask

    task automatic test_abort_drain;
        int  cyc;
        int  t;
        int  idle_cyc;
        bit  saw_done;
        logic [15:0]     keep_res;
        logic [CntW-1:0] keep_cnt;
        keep_res = last_res;
        keep_cnt = last_cnt;
        @(negedge clk);
        start    = 1'b1;
        base_in  = to_mont(longint'(777));
        exp_in   = 8'b0110_0001;
        cyc      = 0;
        t        = -1;
        idle_cyc = -1;
        saw_done = 1'b0;
        while (idle_cyc < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (done) saw_done = 1'b1;
            if (mm_start && t < 0) t = cyc;
            if (t >= 0 && cyc == t + 2) abort = 1'b1;
            if (t >= 0 && cyc > t + 2 && !busy) idle_cyc = cyc;
        end
        abort = 1'b0;
        checks++;
        if (t != 4 || idle_cyc != t + 5) begin
            errors++;
            $display("FAIL abort_drain sqr_cycle=%0d idle_cycle=%0d want 4 9", t, idle_cyc);
        end
        checks++;
        if (saw_done || result !== keep_res || mm_count !== keep_cnt) begin
            errors++;
            $display("FAIL abort_hold done_seen=%b result=%h mm_count=%0d want 0 %h %0d",
                     saw_done, result, mm_count, keep_res, keep_cnt);
        end
        run_job(16'd777, 8'b0110_0001, -1, -1, "after_abort");
    endtask

    task automatic test_ignored;
        run_job(16'd4321, 8'hA5, 1, 3, "ignored");
    endtask

    task automatic test_back_to_back;
        run_job(16'd100, 8'h3C, -1, -1, "b2b_first");
        run_job(16'd200, 8'h81, -1, -1, "b2b_second");
    endtask

    task automatic test_reset_mid;
        int cyc;
        int n;
        @(negedge clk);
        start   = 1'b1;
        base_in = to_mont(longint'(999));
        exp_in  = 8'hFF;
        cyc     = 0;
        n       = 0;
        while (n < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (mm_start) n++;
        end
        checks++;
        if (n != 2 || cyc != 8) begin
            errors++;
            $display("FAIL reset_mid mul_start cycle=%0d count=%0d want 8 2", cyc, n);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_job(16'd999, 8'hFF, -1, -1, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exp5();
        test_exp_zero();
        test_all_ones();
        test_abort_drain();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
